fp_div_sched: RTL and testbench

- Shares one sequential IEEE-754 single-precision divide datapath (A/B) among NREQ requesters.
- Round-robin arbiter selects a requester; a restoring mantissa divider produces one quotient bit per cycle; the result is returned with the requester ID over a valid/ready response channel.
- Sits between the per-lane FP issue logic and the writeback bus; it is the multi-cycle, shared replacement for per-lane combinational dividers.

---
 rtl/fp_div_pkg.sv | 31 +++
 rtl/fp_div_sched_if.sv | 29 ++
 rtl/fp_div_rr_arbiter.sv | 36 +++
 rtl/fp_div_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_fp_div_sched.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_div_pkg.sv
// Shared definitions for the sequential FP32 divide scheduler: bias, quiet NaN,
// flag bit positions, FSM state encoding, iteration count and the FP32 layout.
package fp_div_pkg;

    localparam int unsigned EXP_BIAS = 127;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    // Bit positions inside the 4-bit {nv, dz, of, uf} flag vector
    localparam int unsigned FLAG_NV  = 3;
    localparam int unsigned FLAG_DZ  = 2;
    localparam int unsigned FLAG_OF  = 1;
    localparam int unsigned FLAG_UF  = 0;

    // Quotient bits produced by the restoring divider (integer bit + 23 frac + G + 1)
    localparam int unsigned ITER_CNT = 26;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_ITER,
        ST_NORM,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp_div_sched_if.sv
// Request/response bundle of the shared FP divider.
//   master : requester side (drives operands and rsp_ready)
//   slave  : divider side (drives req_ready and the response)
interface fp_div_sched_if #(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned ID_W = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [31:0]        rsp_result;
    logic [3:0]         rsp_flags;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
    );

endinterface

// File: rtl/fp_div_rr_arbiter.sv
// Combinational round-robin pick: first valid index at or after ptr_i, wrapping.
//   valid_i   : request vector
//   ptr_i     : highest-priority index
//   grant_c_o : one-hot grant (zero when nothing valid)
//   idx_c_o   : index of the granted requester
//   any_c_o   : at least one request valid
module fp_div_rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         valid_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         grant_c_o,
    output logic [$clog2(NREQ)-1:0] idx_c_o,
    output logic                    any_c_o
);
    localparam int unsigned ID_W = $clog2(NREQ);

    logic [ID_W-1:0] cand;

    // Scan NREQ positions starting at the pointer; modulo keeps non-power-of-two NREQ legal
    always_comb begin
        grant_c_o = '0;
        idx_c_o   = '0;
        any_c_o   = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = ID_W'((32'(ptr_i) + k) % NREQ);
            if (!any_c_o && valid_i[cand]) begin
                any_c_o         = 1'b1;
                idx_c_o         = cand;
                grant_c_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_div_sched.sv
// Shared sequential FP32 divider (A/B) serving NREQ requesters round-robin.
// One quotient bit per cycle from a restoring mantissa divider; result returned
// with the owner's ID over a valid/ready channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fp_div_sched_if.slave (requests in, req_ready/response out)
//   busy       : high whenever the FSM is not IDLE
// Build option: define FPDIV_RNE_EN for round-to-nearest-even; default truncates.
module fp_div_sched
    import fp_div_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_div_sched_if.slave  bus,
    output logic           busy
);
    localparam int unsigned ID_W = $clog2(NREQ);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d, id_q, id_d, rsp_id_q, rsp_id_d;
    fp32_t             a_q, a_d, b_q, b_d;
    logic [24:0]       rem_q, rem_d;
    logic [23:0]       div_q, div_d;
    logic [25:0]       quo_q, quo_d;
    logic signed [9:0] exp_q, exp_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              special_q, special_d;
    logic [31:0]       res_q, res_d;
    logic [3:0]        flg_q, flg_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q;

    logic [NREQ-1:0]   gnt_oh;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;

    fp_div_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .valid_i   (bus.req_valid),
        .ptr_i     (ptr_q),
        .grant_c_o (gnt_oh),
        .idx_c_o   (gnt_idx),
        .any_c_o   (gnt_any)
    );

    // Grants only offered in IDLE and never while reset is asserted
    assign bus.req_ready  = (state_q == ST_IDLE && rst_n) ? gnt_oh : '0;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_flags  = flg_q;
    assign busy           = busy_q;

    // Operand classification on the latched operands (exponent 0 counts as zero)
    logic a_zero, b_zero, a_inf, b_inf, any_nan, sign_c;
    assign a_zero  = (a_q.exp == 8'd0);
    assign b_zero  = (b_q.exp == 8'd0);
    assign a_inf   = (a_q.exp == 8'hFF) && (a_q.frac == '0);
    assign b_inf   = (b_q.exp == 8'hFF) && (b_q.frac == '0);
    assign any_nan = ((a_q.exp == 8'hFF) && (a_q.frac != '0)) ||
                     ((b_q.exp == 8'hFF) && (b_q.frac != '0));
    assign sign_c  = a_q.sign ^ b_q.sign;

    // Restoring step: subtract when the partial remainder covers the divisor
    logic        qbit;
    logic [24:0] rem_sub;
    assign qbit    = (rem_q >= {1'b0, div_q});
    assign rem_sub = qbit ? (rem_q - {1'b0, div_q}) : rem_q;

    // Normalisation, optional rounding and range checks
    logic signed [9:0] e_n;
    logic [22:0]       frac_n;
    logic [31:0]       norm_res;
    logic [3:0]        norm_flg;
`ifdef FPDIV_RNE_EN
    logic              g_n, rs_n;
    logic [23:0]       frac_r;
`endif

    always_comb begin
        e_n    = quo_q[25] ? exp_q : (exp_q - 10'sd1);
        frac_n = quo_q[25] ? quo_q[24:2] : quo_q[23:1];
`ifdef FPDIV_RNE_EN
        g_n    = quo_q[25] ? quo_q[1] : quo_q[0];
        rs_n   = (quo_q[25] & quo_q[0]) | (rem_q != '0);
        frac_r = {1'b0, frac_n} + 24'(g_n & (rs_n | frac_n[0]));
        frac_n = frac_r[22:0];
        // Carry out of the fraction bumps the exponent before the overflow check
        if (frac_r[23]) begin
            e_n = e_n + 10'sd1;
        end
`endif
        norm_res = {sign_c, e_n[7:0], frac_n};
        norm_flg = '0;
        if (e_n >= 10'sd255) begin
            norm_res          = {sign_c, 8'hFF, 23'd0};
            norm_flg[FLAG_OF] = 1'b1;
        end else if (e_n <= 10'sd0) begin
            norm_res          = {sign_c, 31'd0};
            norm_flg[FLAG_UF] = 1'b1;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        rsp_id_d    = rsp_id_q;
        a_d         = a_q;
        b_d         = b_q;
        rem_d       = rem_q;
        div_d       = div_q;
        quo_d       = quo_q;
        exp_d       = exp_q;
        cnt_d       = cnt_q;
        special_d   = special_q;
        res_d       = res_q;
        flg_d       = flg_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    a_d     = bus.req_a[32*32'(gnt_idx) +: 32];
                    b_d     = bus.req_b[32*32'(gnt_idx) +: 32];
                    id_d    = gnt_idx;
                    ptr_d   = ID_W'((32'(gnt_idx) + 32'd1) % NREQ);
                    state_d = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                special_d = 1'b1;
                flg_d     = '0;
                if (any_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                    res_d          = QNAN;
                    flg_d[FLAG_NV] = 1'b1;
                end else if (a_inf) begin
                    res_d = {sign_c, 8'hFF, 23'd0};
                end else if (b_zero) begin
                    res_d          = {sign_c, 8'hFF, 23'd0};
                    flg_d[FLAG_DZ] = 1'b1;
                end else if (a_zero || b_inf) begin
                    res_d = {sign_c, 31'd0};
                end else begin
                    special_d = 1'b0;
                    rem_d     = {2'b01, a_q.frac};
                    div_d     = {1'b1, b_q.frac};
                    quo_d     = '0;
                    cnt_d     = '0;
                    exp_d     = $signed(10'(a_q.exp) - 10'(b_q.exp) + 10'(EXP_BIAS));
                end
                state_d = special_d ? ST_NORM : ST_ITER;
            end
            ST_ITER: begin
                rem_d = {rem_sub[23:0], 1'b0};
                quo_d = {quo_q[24:0], qbit};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(ITER_CNT - 1)) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (!special_q) begin
                    res_d = norm_res;
                    flg_d = norm_flg;
                end
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            rsp_id_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            quo_q       <= '0;
            exp_q       <= '0;
            cnt_q       <= '0;
            special_q   <= 1'b0;
            res_q       <= '0;
            flg_q       <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            rsp_id_q    <= rsp_id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rem_q       <= rem_d;
            div_q       <= div_d;
            quo_q       <= quo_d;
            exp_q       <= exp_d;
            cnt_q       <= cnt_d;
            special_q   <= special_d;
            res_q       <= res_d;
            flg_q       <= flg_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_fp_div_sched.sv
// Scoreboard bench for fp_div_sched: driver issues requests, monitor predicts
// grants/results with an arithmetic reference model and checks responses.
module tb_fp_div_sched;

    localparam int unsigned NREQ = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    fp_div_sched_if #(.NREQ(NREQ)) bus ();

    fp_div_sched #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer quotient of the mantissas, then IEEE-style packing
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic [3:0] flg,
                                    output bit spec);
        logic [7:0] ea, eb;
        logic [22:0] fa, fb;
        logic s;
        bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, st;
        longint unsigned ma, mb, num, q, r;
        int e;
        logic [23:0] frac;
        ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
        s = a[31] ^ b[31];
        a_nan = (ea == 8'hFF) && (fa != 0); b_nan = (eb == 8'hFF) && (fb != 0);
        a_inf = (ea == 8'hFF) && (fa == 0); b_inf = (eb == 8'hFF) && (fb == 0);
        a_zero = (ea == 0); b_zero = (eb == 0);
        spec = 1'b1;
        flg = 4'b0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res = 32'h7FC00000; flg = 4'b1000; return;
        end
        if (a_inf) begin res = {s, 8'hFF, 23'd0}; return; end
        if (b_zero) begin res = {s, 8'hFF, 23'd0}; flg = 4'b0100; return; end
        if (a_zero || b_inf) begin res = {s, 31'd0}; return; end
        spec = 1'b0;
        ma = 64'h800000 + 64'(fa);
        mb = 64'h800000 + 64'(fb);
        num = ma << 25;
        q = num / mb;
        r = num % mb;
        e = int'(ea) - int'(eb) + 127;
        if (q >= (64'd1 << 25)) begin
            frac = 24'((q >> 2) & 64'h7FFFFF);
            g = q[1];
            st = q[0] || (r != 0);
        end else begin
            e = e - 1;
            frac = 24'((q >> 1) & 64'h7FFFFF);
            g = q[0];
            st = (r != 0);
        end
`ifdef FPDIV_RNE_EN
        if (g && (st || frac[0])) begin
            frac = frac + 24'd1;
            if (frac[23]) begin
                frac = 24'd0;
                e = e + 1;
            end
        end
`else
        if (g && st) frac = frac;
`endif
        if (e >= 255) begin res = {s, 8'hFF, 23'd0}; flg = 4'b0010; end
        else if (e <= 0) begin res = {s, 31'd0}; flg = 4'b0001; end
        else res = {s, 8'(e), frac[22:0]};
    endfunction

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb_q[$];

    // ---------------- monitor / scoreboard ----------------
    int unsigned ptr_m;
    bit          mbusy;
    bit          seen_v;
    int          cyc;
    int          g_m;
    logic [NREQ-1:0] exp_gnt;
    exp_t        ent;
    exp_t        head;
    bit          spec_m;

    initial begin
        ptr_m = 0; mbusy = 0; seen_v = 0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_rsp_valid",  64'(bus.rsp_valid),  64'd0);
                chk("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
                chk("rst_rsp_flags",  64'(bus.rsp_flags),  64'd0);
                chk("rst_rsp_id",     64'(bus.rsp_id),     64'd0);
                chk("rst_req_ready",  64'(bus.req_ready),  64'd0);
                chk("rst_busy",       64'(busy),           64'd0);
                sb_q.delete();
                ptr_m = 0; mbusy = 0; seen_v = 0;
            end else begin
                chk("busy", 64'(busy), 64'(mbusy));
                g_m = -1;
                exp_gnt = '0;
                if (!mbusy) begin
                    for (int k = 0; k < int'(NREQ); k++) begin
                        if (g_m < 0 && bus.req_valid[(int'(ptr_m) + k) % NREQ])
                            g_m = (int'(ptr_m) + k) % NREQ;
                    end
                end
                if (g_m >= 0) exp_gnt[g_m] = 1'b1;
                chk("req_ready", 64'(bus.req_ready), 64'(exp_gnt));
                if (g_m >= 0) begin
                    ref_div(bus.req_a[32*g_m +: 32], bus.req_b[32*g_m +: 32],
                            ent.res, ent.flg, spec_m);
                    ent.id  = g_m;
                    ent.lat = spec_m ? 2 : 28;
                    ent.t0  = cyc;
                    sb_q.push_back(ent);
                    ptr_m = (g_m + 1) % NREQ;
                    mbusy = 1'b1;
                end
                if (bus.rsp_valid) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_rsp", 64'd1, 64'd0);
                    end else begin
                        head = sb_q[0];
                        if (!seen_v) begin
                            chk("latency", 64'(cyc - head.t0 - 1), 64'(head.lat));
                            seen_v = 1'b1;
                        end
                        chk("rsp_result", 64'(bus.rsp_result), 64'(head.res));
                        chk("rsp_flags",  64'(bus.rsp_flags),  64'(head.flg));
                        chk("rsp_id",     64'(bus.rsp_id),     64'(head.id));
                        if (bus.rsp_ready) begin
                            void'(sb_q.pop_front());
                            seen_v = 1'b0;
                            mbusy  = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    logic        pv [NREQ];
    logic [31:0] pa [NREQ];
    logic [31:0] pb [NREQ];

    task automatic drive();
        for (int i = 0; i < int'(NREQ); i++) begin
            bus.req_valid[i]       = pv[i];
            bus.req_a[32*i +: 32]  = pa[i];
            bus.req_b[32*i +: 32]  = pb[i];
        end
    endtask

    // One clock: drop requests accepted at this edge, re-drive at posedge+1
    task automatic tick();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        acc = bus.req_ready & bus.req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NREQ); i++) if (acc[i]) pv[i] = 1'b0;
        drive();
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
        pv[i] = 1'b1; pa[i] = a; pb[i] = b;
        drive();
    endtask

    function automatic bit any_pending();
        bit r;
        r = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) r |= pv[i];
        return r;
    endfunction

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((any_pending() || sb_q.size() != 0 || busy) && n < max) begin
            tick();
            n++;
        end
        if (n >= max) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    function automatic logic [31:0] rnd_op();
        int unsigned k;
        logic s;
        logic [22:0] f;
        logic [7:0] e;
        k = $urandom_range(0, 15);
        s = 1'($urandom);
        f = 23'($urandom);
        case (k)
            0: return {s, 8'h00, 23'd0};
            1: return {s, 8'h00, f | 23'd1};
            2: return {s, 8'hFF, 23'd0};
            3: return {s, 8'hFF, f | 23'd1};
            4: e = 8'($urandom_range(1, 8));
            5: e = 8'($urandom_range(246, 254));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {s, e, f};
    endfunction

    function automatic logic [31:0] rnd_norm();
        return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    int n_wait;
    bit re0;

    initial begin
        for (int i = 0; i < int'(NREQ); i++) begin
            pv[i] = 1'b0; pa[i] = '0; pb[i] = '0;
        end
        drive();
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors, one requester at a time
        bus.rsp_ready = 1'b1;
        issue(0, 32'h40C00000, 32'h40000000); drain(100);
        issue(0, 32'h3F800000, 32'h40400000); drain(100);
        issue(1, 32'h3F800000, 32'h00000000); drain(100);
        issue(2, 32'h00000000, 32'h00000000); drain(100);
        issue(3, 32'h7F000000, 32'h3E800000); drain(100);
        issue(0, 32'h00800000, 32'h40000000); drain(100);
        issue(1, 32'h7F800000, 32'h40000000); drain(100);
        issue(2, 32'h40000000, 32'h7F800000); drain(100);
        issue(3, 32'h7FC00001, 32'h3F800000); drain(100);

        // All requesters contend; response back-pressure held for long stretches
        issue(1, 32'h40000000, 32'h40000000); drain(100);   // moves pointer to 2
        issue(3, 32'h41200000, 32'h40A00000); drain(100);   // pointer back to 0
        for (int i = 0; i < int'(NREQ); i++) issue(i, rnd_norm(), rnd_norm());
        re0 = 1'b0;
        for (int c = 0; c < 300; c++) begin
            bus.rsp_ready = ((c % 9) == 8);
            tick();
            if (!re0 && !pv[0]) begin
                issue(0, rnd_norm(), rnd_norm());
                re0 = 1'b1;
            end
        end
        bus.rsp_ready = 1'b1;
        drain(400);

        // Reset during the divide loop, then a fresh request
        issue(0, 32'h40C00000, 32'h40000000);
        n_wait = 0;
        while (pv[0] && n_wait < 20) begin tick(); n_wait++; end
        if (n_wait >= 20) chk("grant_timeout", 64'd1, 64'd0);
        repeat (10) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        issue(0, 32'h40C00000, 32'h40000000); drain(100);

        // Randomised traffic with random back-pressure
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < int'(NREQ); i++)
                if (!pv[i] && $urandom_range(0, 9) == 0) issue(i, rnd_op(), rnd_op());
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        drain(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
